// File: rtl/fan_ctrl_if.sv
// Signal bundle between the desk-fan control FSM and its surroundings:
// switch/keys/raw temperature in, gear/temperature/timer/PWM out.
interface fan_ctrl_if;
    logic       sw;
    logic       key_gear;
    logic       key_mode;
    logic       key_time;
    logic [5:0] Tem_in;
    logic [2:0] D;
    logic [5:0] Tem;
    logic [5:0] Time;
    logic       auto_mode;
    logic       fan_pwm;

    modport master (
        output sw, key_gear, key_mode, key_time, Tem_in,
        input  D, Tem, Time, auto_mode, fan_pwm
    );

    modport slave (
        input  sw, key_gear, key_mode, key_time, Tem_in,
        output D, Tem, Time, auto_mode, fan_pwm
    );
endinterface

// File: rtl/fan_ctrl.sv
// Desk-fan control FSM: OFF/MANUAL/AUTO/EXPIRED with gear selection,
// countdown timer, temperature clamp and a gear-proportional motor PWM.
module fan_ctrl #(
    parameter int TICK_DIV   = 1000,
    parameter int PWM_PERIOD = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    fan_ctrl_if.slave bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
    localparam logic [7:0]    DUTY_STEP = 8'(PWM_PERIOD / 4);

    typedef enum logic [1:0] {OFF, MANUAL, AUTO, EXPIRED} state_t;

    state_t        state_reg;
    logic [2:0]    d_reg;
    logic [5:0]    time_reg;
    logic [5:0]    tem_reg;
    logic [TW-1:0] tick_reg;
    logic          auto_reg;
    logic [PW-1:0] pwm_cnt_reg;
    logic          pwm_reg;

    // Bit order: 0 = sw, 1 = key_gear, 2 = key_mode, 3 = key_time
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] act;
    assign raw = {bus.key_time, bus.key_mode, bus.key_gear, bus.sw};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        logic s1_reg, s2_reg, s3_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_reg <= 1'b0;
                s2_reg <= 1'b0;
                s3_reg <= 1'b0;
            end else begin
                s1_reg <= raw[gi];
                s2_reg <= s1_reg;
                s3_reg <= s2_reg;
            end
        end
        assign lvl[gi] = s2_reg;
        assign act[gi] = s2_reg & ~s3_reg;
    end

    // The switch acts on its level and the keys on their rising edge only.
    logic unused_sync;
    assign unused_sync = ^{act[0], lvl[3:1]};

    logic sw_on, gear_act, mode_act, time_act;
    assign sw_on    = lvl[0];
    assign gear_act = act[1];
    assign mode_act = act[2];
    assign time_act = act[3];

    logic running, expire;
    assign running = (state_reg == MANUAL) || (state_reg == AUTO);
    // A key_time action on the final tick suppresses the decrement, hence the expiry too.
    assign expire  = running && !time_act && (time_reg == 6'd1) && (tick_reg == TICK_LAST);

    logic [2:0] auto_gear;
    always_comb begin
        auto_gear = 3'd4;
        if (tem_reg < 6'd20)      auto_gear = 3'd1;
        else if (tem_reg < 6'd28) auto_gear = 3'd2;
        else if (tem_reg < 6'd34) auto_gear = 3'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= OFF;
            d_reg     <= 3'd0;
            time_reg  <= 6'd0;
            tick_reg  <= '0;
            auto_reg  <= 1'b0;
        end else if (!sw_on) begin
            state_reg <= OFF;
            d_reg     <= 3'd0;
            time_reg  <= 6'd0;
            tick_reg  <= '0;
            auto_reg  <= 1'b0;
        end else begin
            case (state_reg)
                OFF: begin
                    state_reg <= MANUAL;
                    d_reg     <= 3'd1;
                    time_reg  <= 6'd0;
                    tick_reg  <= '0;
                    auto_reg  <= 1'b0;
                end
                MANUAL, AUTO: begin
                    if (time_act) begin
                        tick_reg <= '0;
                        if (time_reg == 6'd0)       time_reg <= 6'd10;
                        else if (time_reg == 6'd39) time_reg <= 6'd0;
                        else                        time_reg <= time_reg + 6'd1;
                    end else if (time_reg != 6'd0) begin
                        if (tick_reg == TICK_LAST) begin
                            tick_reg <= '0;
                            time_reg <= time_reg - 6'd1;
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end else begin
                        tick_reg <= '0;
                    end

                    if (expire) begin
                        state_reg <= EXPIRED;
                        d_reg     <= 3'd0;
                        auto_reg  <= 1'b0;
                    end else if (mode_act) begin
                        if (state_reg == MANUAL) begin
                            state_reg <= AUTO;
                            auto_reg  <= 1'b1;
                        end else begin
                            state_reg <= MANUAL;
                            auto_reg  <= 1'b0;
                        end
                    end else if (state_reg == MANUAL) begin
                        if (gear_act) d_reg <= (d_reg == 3'd4) ? 3'd1 : d_reg + 3'd1;
                    end else begin
                        d_reg <= auto_gear;
                    end
                end
                EXPIRED: begin
                    d_reg    <= 3'd0;
                    time_reg <= 6'd0;
                    tick_reg <= '0;
                    auto_reg <= 1'b0;
                end
                default: state_reg <= OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tem_reg <= 6'd10;
        end else if (bus.Tem_in < 6'd10) begin
            tem_reg <= 6'd10;
        end else if (bus.Tem_in > 6'd40) begin
            tem_reg <= 6'd40;
        end else begin
            tem_reg <= bus.Tem_in;
        end
    end

    // Counter never restarts on a gear change; the new duty applies from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= '0;
            pwm_reg     <= 1'b0;
        end else begin
            pwm_cnt_reg <= (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
            pwm_reg     <= 8'(pwm_cnt_reg) < (8'(d_reg) * DUTY_STEP);
        end
    end

    assign bus.D         = d_reg;
    assign bus.Tem       = tem_reg;
    assign bus.Time      = time_reg;
    assign bus.auto_mode = auto_reg;
    assign bus.fan_pwm   = pwm_reg;
endmodule

// File: tb/tb_fan_ctrl.sv
// Directed bench for fan_ctrl with TICK_DIV=4 and PWM_PERIOD=8; every
// expected value below is worked out by hand from the cycle timing.
module tb_fan_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    fan_ctrl_if bus();

    fan_ctrl #(.TICK_DIV(4), .PWM_PERIOD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-12s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 0 = gear, 1 = mode, 2 = time; effect is registered by the time this returns
    task automatic press(input int which);
        case (which)
            0: bus.key_gear = 1'b1;
            1: bus.key_mode = 1'b1;
            default: bus.key_time = 1'b1;
        endcase
        cyc(1);
        bus.key_gear = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_time = 1'b0;
        cyc(2);
    endtask

    task automatic pwm_highs(output int n);
        n = 0;
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            n += int'(bus.fan_pwm);
            cyc(1);
        end
    endtask

    int gear_seq [5] = '{2, 3, 4, 1, 2};
    int tem_tab  [11][3] = '{
        '{5, 10, 1}, '{19, 19, 1}, '{20, 20, 2}, '{27, 27, 2}, '{28, 28, 3},
        '{33, 33, 3}, '{34, 34, 4}, '{25, 25, 2}, '{45, 40, 4}, '{63, 40, 4},
        '{30, 30, 3}
    };

    initial begin
        int highs;
        rst_n        = 1'b0;
        bus.sw       = 1'b1;
        bus.key_gear = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_time = 1'b0;
        bus.Tem_in   = 6'd25;

        // Reset with the switch already on
        cyc(4);
        check("rst_D", 32'(bus.D), 0);
        check("rst_Time", 32'(bus.Time), 0);
        check("rst_pwm", 32'(bus.fan_pwm), 0);
        check("rst_Tem", 32'(bus.Tem), 10);
        check("rst_auto", 32'(bus.auto_mode), 0);
        rst_n = 1'b1;
        cyc(2);
        check("start_D_2", 32'(bus.D), 0);
        cyc(1);
        check("start_D_3", 32'(bus.D), 1);
        cyc(2);
        pwm_highs(highs);
        check("pwm_d1", 32'(highs), 2);

        // Manual gear cycling
        for (int i = 0; i < 5; i++) begin
            press(0);
            check("gear_press", 32'(bus.D), 32'(gear_seq[i]));
            if (gear_seq[i] == 4) begin
                pwm_highs(highs);
                check("pwm_d4", 32'(highs), 8);
            end
        end
        bus.key_gear = 1'b1;
        cyc(50);
        bus.key_gear = 1'b0;
        cyc(3);
        check("gear_hold", 32'(bus.D), 3);

        // Automatic mode from temperature
        press(1);
        check("auto_on", 32'(bus.auto_mode), 1);
        for (int i = 0; i < 11; i++) begin
            bus.Tem_in = 6'(tem_tab[i][0]);
            cyc(2);
            check("auto_Tem", 32'(bus.Tem), 32'(tem_tab[i][1]));
            check("auto_D", 32'(bus.D), 32'(tem_tab[i][2]));
        end
        press(0);
        check("auto_gear_ign", 32'(bus.D), 3);
        press(1);
        check("manual_auto", 32'(bus.auto_mode), 0);
        check("manual_D", 32'(bus.D), 3);
        bus.Tem_in = 6'd5;
        cyc(3);
        check("manual_Dhold", 32'(bus.D), 3);
        check("manual_Tem", 32'(bus.Tem), 10);

        // Timer set sequence 10..39 then cancel
        press(2);
        check("time_first", 32'(bus.Time), 10);
        for (int t = 11; t <= 39; t++) begin
            press(2);
            check("time_inc", 32'(bus.Time), 32'(t));
        end
        press(2);
        check("time_cancel", 32'(bus.Time), 0);
        cyc(10);
        check("time_idle", 32'(bus.Time), 0);

        // key_time action landing on a tick wrap at Time=15
        for (int i = 0; i < 6; i++) press(2);
        check("time_15", 32'(bus.Time), 15);
        cyc(1);
        bus.key_time = 1'b1;
        cyc(1);
        bus.key_time = 1'b0;
        cyc(2);
        check("wrap_key", 32'(bus.Time), 16);
        cyc(3);
        check("wrap_hold", 32'(bus.Time), 16);
        cyc(1);
        check("wrap_dec", 32'(bus.Time), 15);

        // Switch off mid-countdown
        bus.sw = 1'b0;
        cyc(2);
        check("swoff_late", 32'(bus.Time), 15);
        cyc(1);
        check("swoff_D", 32'(bus.D), 0);
        check("swoff_Time", 32'(bus.Time), 0);
        bus.sw = 1'b1;
        cyc(3);
        check("swon_D", 32'(bus.D), 1);

        // Countdown to expiry
        press(2);
        cyc(31);
        check("cd_3", 32'(bus.Time), 3);
        cyc(1);
        check("cd_2", 32'(bus.Time), 2);
        cyc(7);
        check("cd_1", 32'(bus.Time), 1);
        check("cd_D", 32'(bus.D), 1);
        cyc(1);
        check("exp_Time", 32'(bus.Time), 0);
        check("exp_D", 32'(bus.D), 0);
        cyc(1);
        check("exp_pwm", 32'(bus.fan_pwm), 0);
        press(0);
        press(2);
        cyc(5);
        check("exp_keys_D", 32'(bus.D), 0);
        check("exp_keys_T", 32'(bus.Time), 0);
        bus.sw = 1'b0;
        cyc(3);
        bus.sw = 1'b1;
        cyc(3);
        check("restart_D", 32'(bus.D), 1);

        // Asynchronous reset in AUTO mid-countdown
        press(1);
        bus.Tem_in = 6'd30;
        cyc(2);
        check("pre_rst_D", 32'(bus.D), 3);
        press(2);
        check("pre_rst_T", 32'(bus.Time), 10);
        cyc(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_D", 32'(bus.D), 0);
        check("arst_Time", 32'(bus.Time), 0);
        check("arst_Tem", 32'(bus.Tem), 10);
        check("arst_auto", 32'(bus.auto_mode), 0);
        check("arst_pwm", 32'(bus.fan_pwm), 0);
        cyc(2);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fan_ctrl.md
Name: fan_ctrl

Overview:
- Central control FSM for the desk-fan experiment. Converts the power switch, three push-keys and the temperature sensor value into the gear, clamped temperature, timer value and motor PWM.
- Runs on the same 1 kHz clock as the seven-segment display driver.
- D, Tem and Time connect directly to that driver's inputs of the same names.

Parameters:
- TICK_DIV, 1000: clk cycles per timer unit (1 s at 1 kHz).
- PWM_PERIOD, 8: fan PWM period in clk cycles. Must be a multiple of 4 and at most 64.

Ports:
- clk  in  1  1 kHz system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  1  power switch, level; 1 = on.
- key_gear  in  1  gear key, debounced level, active high.
- key_mode  in  1  manual/auto toggle key, debounced level, active high.
- key_time  in  1  timer-set key, debounced level, active high.
- Tem_in  in  6  raw temperature, degrees C, 0..63.
- D  out  3  current gear, 0 = stopped, 1..4 = running.
- Tem  out  6  clamped temperature, 10..40.
- Time  out  6  remaining timer units, 0 = no timer.
- auto_mode  out  1  1 while in AUTO state.
- fan_pwm  out  1  motor drive.

Behaviour:
- Reset (rst_n=0, async): state=OFF; D=0, Tem=10, Time=0, auto_mode=0, fan_pwm=0. All synchronizers, tick counter and PWM counter are cleared.
- Keys and sw:
  - Each passes through a 2-FF synchronizer plus one delay FF. Action pulse = s2 & ~s3.
  - A key first sampled high at edge k takes effect in the registers at edge k+2.
  - Holding a key gives exactly one action. Keys are ignored in OFF and EXPIRED.
- Tem: registered every cycle as Tem_in clamped to the range 10..40 (below 10 gives 10, above 40 gives 40). Updated in all states.
- States: OFF, MANUAL, AUTO, EXPIRED.
  - OFF: D=0, Time=0. When synchronized sw=1, go to MANUAL with D=1, Time=0.
  - MANUAL: a key_gear action cycles D 1→2→3→4→1. A key_mode action goes to AUTO.
  - AUTO: D is recomputed every cycle from registered Tem: Tem<20 gives 1; 20..27 gives 2; 28..33 gives 3; ≥34 gives 4. key_gear is ignored. A key_mode action goes to MANUAL and holds the current D.
  - EXPIRED: D=0, Time=0, fan_pwm=0. Stays here until synchronized sw=0, which goes to OFF. A switch-off/on cycle is therefore required to restart.
  - From any state, synchronized sw=0 goes to OFF. This has the highest priority and clears Time, D, auto_mode and the tick counter.
- auto_mode = (state==AUTO), registered.
- Timer (MANUAL/AUTO only):
  - key_time action: if Time==0, Time=10. Else if Time==39, Time=0 (timer cancelled). Else Time=Time+1. Every key_time action clears the tick counter.
  - With Time≠0, the tick counter counts 0..TICK_DIV-1. On wrap, Time decrements by 1.
  - Countdown may pass below 10.
  - The decrement from 1 to 0 moves the state to EXPIRED on that same edge.
  - With Time==0, the tick counter is held at 0.
- Simultaneous events:
  - sw off beats everything.
  - Expiry beats key_gear and key_mode.
  - A key_time action and a tick wrap in the same cycle: the key action wins and the decrement is dropped.
  - key_gear and key_mode in the same cycle: the mode change wins and key_gear is ignored.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1, reset to 0.
  - fan_pwm registered = (cnt < D*PWM_PERIOD/4).
  - D=4 gives constant 1; D=0 gives constant 0.
  - Duty changes take effect on the next counter value, with no restart.

Test Plan:
- Reset with sw=1 already high → D=0, Time=0, fan_pwm=0 during reset. After release: D=1 within 3 cycles; fan_pwm at 25% duty (2 of 8 cycles high).
- MANUAL: 5 key_gear presses → D sequence 2,3,4,1,2. Holding key_gear high for 50 cycles advances D by exactly 1.
- Tem_in = 5, 25, 30, 45 in AUTO → Tem = 10, 25, 30, 40 and D = 1, 2, 3, 4. key_gear ignored. key_mode → MANUAL with D unchanged and auto_mode=0.
- key_time ×1 → Time=10. Then 29 more presses → 39, one more → 0. With TICK_DIV=4: Time=2 → after 8 cycles Time=0, state EXPIRED, D=0. sw 1→0→1 → MANUAL, D=1.
- key_time action on the same cycle as a tick wrap at Time=15 → Time=16 and tick counter=0. sw dropped mid-countdown → D=0, Time=0 within 3 cycles.
- Assert rst_n low mid-countdown in AUTO with D=3 → all outputs at reset values immediately, asynchronously, before the next clk edge.
